// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO sequencer: op codes, FSM encoding, defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package md_pkg;

    localparam int XLEN = 32;

    // Default watchdog limit on cycles spent waiting for a unit's ready
    localparam int MAX_CYCLES_DEF = 40;

    // HI/LO-class op codes; 6 and 7 are ignored by the sequencer
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Sequencer FSM encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MUL_BUSY = 2'd1;
    localparam logic [1:0] ST_DIV_BUSY = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // MULT and DIV are signed; MULTU and DIVU unsigned
    function automatic logic op_is_signed(input logic [2:0] code);
        return (code == OP_MULT) || (code == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair with independent and joint write ports.
// Latency: a write at edge n is visible on o_hi/o_lo in cycle n+1.
// Backpressure: none, every write enable is honoured the cycle it is asserted.
//
// Ports: clk, rst (sync, active-high); i_hi_we/i_hi_d, i_lo_we/i_lo_d single-half
// writes; i_joint_we/i_joint_d 64-bit {HI,LO} write (wins over the halves);
// o_hi, o_lo current values.
module hilo_reg
    import md_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hi_we,
    input  logic [XLEN-1:0]   i_hi_d,
    input  logic              i_lo_we,
    input  logic [XLEN-1:0]   i_lo_d,
    input  logic              i_joint_we,
    input  logic [2*XLEN-1:0] i_joint_d,
    output logic [XLEN-1:0]   o_hi,
    output logic [XLEN-1:0]   o_lo
);

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_joint_we) begin
            r_hi <= i_joint_d[2*XLEN-1:XLEN];
            r_lo <= i_joint_d[XLEN-1:0];
        end else begin
            if (i_hi_we) r_hi <= i_hi_d;
            if (i_lo_we) r_lo <= i_lo_d;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_sched.sv
// EX-stage sequencer for HI/LO-class ops: starts the iterative mul/div, owns HI/LO.
// Latency: MTHI/MTLO and divide-by-zero 0 stall cycles; MUL/DIV stall = unit latency.
// Backpressure: stall_req holds IF/ID/EX while a unit is busy; a watchdog abandons a stuck unit.
//
// Ports: clk/rst (sync, active-high); op_valid/op_code/op_a/op_b instruction in EX;
// ex_advance EX register loads; flush annuls EX; stall_req; hi_o/lo_o; mul_* and div_*
// start/ready handshakes to the units (div_annul aborts the divider); err_timeout sticky.
module muldiv_sched
    import md_pkg::*;
#(
    parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic              ex_advance,
    input  logic              flush,
    output logic              stall_req,
    output logic [XLEN-1:0]   hi_o,
    output logic [XLEN-1:0]   lo_o,
    output logic              mul_start,
    output logic              mul_signed,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    input  logic              mul_ready,
    input  logic [2*XLEN-1:0] mul_result,
    output logic              div_start,
    output logic              div_signed,
    output logic              div_annul,
    output logic [XLEN-1:0]   div_a,
    output logic [XLEN-1:0]   div_b,
    input  logic              div_ready,
    input  logic [2*XLEN-1:0] div_result,
    output logic              err_timeout
);

    localparam int CW = $clog2(MAX_CYCLES + 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic            r_signed;
    logic [CW-1:0]   r_wd_cnt;
    logic            r_err;

    logic w_idle, w_mul_busy, w_div_busy, w_busy;
    logic w_is_mul, w_is_div, w_take;
    logic w_acc_mul, w_acc_div, w_div_zero, w_mthi, w_mtlo, w_instant;
    logic w_ready, w_timeout, w_commit;
    logic [2*XLEN-1:0] w_joint_d;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_mul_busy = (r_state == ST_MUL_BUSY);
    assign w_div_busy = (r_state == ST_DIV_BUSY);
    assign w_busy     = w_mul_busy | w_div_busy;

    // Decode of the instruction offered in IDLE; a flush annuls it before acceptance
    assign w_is_mul   = (op_code == OP_MULT) || (op_code == OP_MULTU);
    assign w_is_div   = (op_code == OP_DIV)  || (op_code == OP_DIVU);
    assign w_take     = w_idle & op_valid & ~flush;
    assign w_acc_mul  = w_take & w_is_mul;
    assign w_acc_div  = w_take & w_is_div & (op_b != '0);
    assign w_div_zero = w_take & w_is_div & (op_b == '0);
    assign w_mthi     = w_take & (op_code == OP_MTHI);
    assign w_mtlo     = w_take & (op_code == OP_MTLO);
    assign w_instant  = w_div_zero | w_mthi | w_mtlo;

    assign w_ready = (w_mul_busy & mul_ready) | (w_div_busy & div_ready);

    // Watchdog outranks a same-cycle ready; flush outranks both
    assign w_timeout = w_busy & ~flush & (r_wd_cnt == CW'(MAX_CYCLES - 1));
    assign w_commit  = w_busy & ~flush & ~w_timeout & w_ready;

    assign stall_req = w_acc_mul | w_acc_div | (w_busy & ~w_ready & ~flush & ~w_timeout);

    // Start is a level held for the whole operation; operands come straight from
    // EX in the accept cycle and from the latches afterwards so they never move.
    assign mul_start  = w_acc_mul | (w_mul_busy & ~flush);
    assign div_start  = w_acc_div | (w_div_busy & ~flush);
    assign div_annul  = w_div_busy & (flush | w_timeout);
    assign mul_a      = w_idle ? op_a : r_a;
    assign mul_b      = w_idle ? op_b : r_b;
    assign mul_signed = w_idle ? op_is_signed(op_code) : r_signed;
    assign div_a      = mul_a;
    assign div_b      = mul_b;
    assign div_signed = mul_signed;

    assign err_timeout = r_err;

    // Ops that complete in the accept cycle skip DONE when EX advances on the same
    // edge, so a back-to-back HI/LO op in the next slot is not mistaken for a replay.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc_mul)      w_state_nxt = ST_MUL_BUSY;
                    else if (w_acc_div) w_state_nxt = ST_DIV_BUSY;
                    else if (w_instant) w_state_nxt = ex_advance ? ST_IDLE : ST_DONE;
                end
                ST_MUL_BUSY, ST_DIV_BUSY: begin
                    if (w_timeout)    w_state_nxt = ST_IDLE;
                    else if (w_ready) w_state_nxt = ex_advance ? ST_IDLE : ST_DONE;
                end
                ST_DONE: begin
                    if (ex_advance) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc_mul | w_acc_div) begin
                r_a      <= op_a;
                r_b      <= op_b;
                r_signed <= op_is_signed(op_code);
                r_wd_cnt <= '0;
            end else if (w_busy) begin
                r_wd_cnt <= r_wd_cnt + CW'(1);
            end
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign w_joint_d = w_div_zero ? {op_a, {XLEN{1'b1}}} : (w_mul_busy ? mul_result : div_result);

    hilo_reg u_hilo (
        .clk        (clk),
        .rst        (rst),
        .i_hi_we    (w_mthi),
        .i_hi_d     (op_a),
        .i_lo_we    (w_mtlo),
        .i_lo_d     (op_a),
        .i_joint_we (w_div_zero | w_commit),
        .i_joint_d  (w_joint_d),
        .o_hi       (hi_o),
        .o_lo       (lo_o)
    );

endmodule
